// File: rtl/spi_ctrlr.sv
// SPI byte-stream register controller: 2-byte command/data
// transactions mapping a chip ID, switches and LEDs.
module spi_ctrlr #(
  parameter logic [7:0] CHIP_ID = 8'h07
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  input  logic        new_data,
  input  logic [7:0]  din,
  output logic [7:0]  dout
);

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_DUMMY
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  led_lo_q, led_lo_d;
  logic [7:0]  led_hi_q, led_hi_d;
  logic [7:0]  dout_q, dout_d;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic [7:0]  rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      led_lo_q  <= '0;
      led_hi_q  <= '0;
      dout_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      led_lo_q  <= led_lo_d;
      led_hi_q  <= led_hi_d;
      dout_q    <= dout_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Read decode uses the address in the command byte itself
  always_comb begin
    rd_data = 8'h00;
    unique case (din[6:0])
      7'h00:   rd_data = CHIP_ID;
      7'h01:   rd_data = sw_sync_q[7:0];
      7'h02:   rd_data = sw_sync_q[15:8];
      7'h03:   rd_data = led_lo_q;
      7'h04:   rd_data = led_hi_q;
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    led_lo_d = led_lo_q;
    led_hi_d = led_hi_q;
    dout_d   = dout_q;
    if (new_data) begin
      unique case (state_q)
        IDLE: begin
          if (din[7]) begin
            dout_d  = rd_data;
            state_d = RD_DUMMY;
          end else begin
            addr_d  = din[6:0];
            state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          if (addr_q == 7'h03) led_lo_d = din;
          if (addr_q == 7'h04) led_hi_d = din;
          state_d = IDLE;
        end
        RD_DUMMY: state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  assign leds = {led_hi_q, led_lo_q};
  assign dout = dout_q;

endmodule

// File: tb/tb_spi_ctrlr.sv
// Directed self-checking bench for spi_ctrlr.
// Inputs change and outputs are sampled on the falling edge.
module tb_spi_ctrlr;

  logic        clk;
  logic        rst;
  logic [15:0] switches;
  logic [15:0] leds;
  logic        new_data;
  logic [7:0]  din;
  logic [7:0]  dout;

  int checks = 0;
  int errors = 0;

  spi_ctrlr dut (
    .clk      (clk),
    .rst      (rst),
    .switches (switches),
    .leds     (leds),
    .new_data (new_data),
    .din      (din),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    din      = b;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    din      = 8'hxx;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b0;
    switches = 16'h0000;
    new_data = 1'b0;
    din      = 8'h00;
    idle(3);
    chk("rst_leds", leds, 16'h0000);
    chk("rst_dout", {8'h00, dout}, 16'h0007 & 16'h0000);
    rst = 1'b1;

    // din ignored without strobe
    din = 8'h03; idle(1);
    din = 8'hFF; idle(1);
    din = 8'h00; idle(1);
    din = 8'h03; idle(1);
    din = 8'hFF; idle(1);
    chk("nostrobe_leds", leds, 16'h0000);
    chk("nostrobe_dout", {8'h00, dout}, 16'h0000);

    // chip id twice, dummy not a command
    send(8'h80);
    chk("chipid_1", {8'h00, dout}, 16'h0007);
    send(8'h00);
    send(8'h80);
    chk("chipid_2", {8'h00, dout}, 16'h0007);
    send(8'h00);

    // switches through synchronizer
    switches = 16'h00FF;
    idle(4);
    send(8'h81);
    chk("sw_lo", {8'h00, dout}, 16'h00FF);
    send(8'h81);
    send(8'h82);
    chk("sw_hi", {8'h00, dout}, 16'h0000);
    send(8'h82);

    // two-flop latency: strobe lands 2 edges after change
    switches = 16'h34FF;
    send(8'h82);
    chk("sync_old", {8'h00, dout}, 16'h0000);
    send(8'h00);
    send(8'h82);
    chk("sync_new", {8'h00, dout}, 16'h0034);
    send(8'h00);

    // LED writes and readback
    send(8'h03); send(8'hFF);
    chk("led_lo_wr", leds, 16'h00FF);
    send(8'h04); send(8'hAA);
    chk("led_hi_wr", leds, 16'hAAFF);
    send(8'h83);
    chk("led_lo_rd", {8'h00, dout}, 16'h00FF);
    send(8'h00);
    send(8'h84);
    chk("led_hi_rd", {8'h00, dout}, 16'h00AA);
    send(8'h00);

    // writes leave dout alone
    send(8'h03); send(8'h00);
    send(8'h04); send(8'h00);
    chk("led_clear", leds, 16'h0000);
    chk("dout_hold", {8'h00, dout}, 16'h00AA);

    // read-only and unmapped addresses
    send(8'h01); send(8'h55);
    chk("ro_leds", leds, 16'h0000);
    send(8'h81);
    chk("ro_sw_lo", {8'h00, dout}, 16'h00FF);
    send(8'h00);
    send(8'h10); send(8'h77);
    chk("unmapped_wr", leds, 16'h0000);
    send(8'h90);
    chk("unmapped_rd", {8'h00, dout}, 16'h0000);
    send(8'h00);

    // reset aborts a pending write
    send(8'h84);
    chk("pre_rst_dout", {8'h00, dout}, 16'h0000);
    send(8'h00);
    send(8'h83);
    chk("pre_rst_lo", {8'h00, dout}, 16'h0000);
    send(8'h00);
    send(8'h03); send(8'h11);
    chk("pre_rst_led", leds, 16'h0011);
    send(8'h81);
    chk("pre_rst_rd", {8'h00, dout}, 16'h00FF);
    send(8'h00);
    send(8'h03);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("mid_rst_leds", leds, 16'h0000);
    chk("mid_rst_dout", {8'h00, dout}, 16'h0000);
    idle(2);
    rst = 1'b1;
    idle(1);
    send(8'h04); send(8'h5A);
    chk("post_rst_leds", leds, 16'h5A00);
    send(8'h84);
    chk("post_rst_rd", {8'h00, dout}, 16'h005A);
    send(8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
